// File: rtl/ise_dpram_1kx24.sv
// 1024 x 24 true dual-port synchronous RAM, single clock, read-first on both ports.
// Registered outputs with a synchronous output-only reset; memory contents survive reset.
module ise_dpram_1kx24 #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic wr_a;
  logic wr_b;

  always_comb begin
    wr_a = ena & wea;
    wr_b = enb & web;
  end

  // Port B is written first so that on an address collision port A's value lands last and wins.
  always_ff @(posedge clk) begin
    if (wr_b)
      mem[addrb] <= dinb;
    if (wr_a)
      mem[addra] <= dina;
  end

  // Outputs sample the pre-edge array contents, giving read-first behaviour on both ports.
  always_ff @(posedge clk) begin
    if (reset)
      douta <= '0;
    else if (ena)
      douta <= mem[addra];
  end

  always_ff @(posedge clk) begin
    if (reset)
      doutb <= '0;
    else if (enb)
      doutb <= mem[addrb];
  end

endmodule

// File: tb/tb_ise_dpram_1kx24.sv
// Directed bench for ise_dpram_1kx24: reset, hold, read-first, collisions, enable gating.
module tb_ise_dpram_1kx24;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena, wea, enb, web;
  logic [9:0]  addra, addrb;
  logic [23:0] dina, dinb;
  logic [23:0] douta, doutb;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ise_dpram_1kx24 #(.ADDR_WIDTH(10), .DATA_WIDTH(24), .DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic we, input logic [9:0] ad, input logic [23:0] d);
    ena = en; wea = we; addra = ad; dina = d;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [9:0] ad, input logic [23:0] d);
    enb = en; web = we; addrb = ad; dinb = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_a(1'b1, 1'b0, 10'd0, 24'h0);
    set_b(1'b1, 1'b0, 10'd0, 24'h0);

    // 1. reset then hold
    tick; tick;
    check("rst_a", douta, 24'h0);
    check("rst_b", doutb, 24'h0);
    reset = 1'b0;
    set_a(1'b0, 1'b0, 10'd0, 24'h0);
    set_b(1'b0, 1'b0, 10'd0, 24'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("hold0_a", douta, 24'h0);
      check("hold0_b", doutb, 24'h0);
    end

    // 2. basic write then read on each port
    set_a(1'b1, 1'b1, 10'o17, 24'o12345670);
    tick;
    check("wr_rf_a", douta, 24'h0);
    set_a(1'b0, 1'b0, 10'o17, 24'h0);
    set_b(1'b1, 1'b0, 10'o17, 24'h0);
    tick;
    check("rd17_b", doutb, 24'o12345670);
    set_a(1'b1, 1'b0, 10'o17, 24'h0);
    set_b(1'b0, 1'b0, 10'd0, 24'h0);
    tick;
    check("rd17_a", douta, 24'o12345670);
    check("hold17_b", doutb, 24'o12345670);

    // 3. read-first and mixed-port read-during-write on addr 5
    set_a(1'b1, 1'b1, 10'd5, 24'h000001);
    tick;
    set_a(1'b1, 1'b1, 10'd5, 24'hABCDEF);
    set_b(1'b1, 1'b0, 10'd5, 24'h0);
    tick;
    check("rf5_a", douta, 24'h000001);
    check("rf5_b", doutb, 24'h000001);
    set_a(1'b1, 1'b0, 10'd5, 24'h0);
    tick;
    check("new5_a", douta, 24'hABCDEF);
    check("new5_b", doutb, 24'hABCDEF);

    // 4. collisions
    set_a(1'b1, 1'b1, 10'd1023, 24'h111111);
    set_b(1'b1, 1'b1, 10'd1023, 24'h222222);
    tick;
    check("col_rf_a", douta, 24'h0);
    check("col_rf_b", doutb, 24'h0);
    set_a(1'b1, 1'b0, 10'd1023, 24'h0);
    set_b(1'b1, 1'b0, 10'd1023, 24'h0);
    tick;
    check("col_a", douta, 24'h111111);
    check("col_b", doutb, 24'h111111);
    set_a(1'b1, 1'b1, 10'd0, 24'h111111);
    set_b(1'b1, 1'b1, 10'd1, 24'h222222);
    tick;
    set_a(1'b1, 1'b0, 10'd0, 24'h0);
    set_b(1'b1, 1'b0, 10'd1, 24'h0);
    tick;
    check("m0_a", douta, 24'h111111);
    check("m1_b", doutb, 24'h222222);

    // 5. enable gating: write ignored, output held
    set_a(1'b0, 1'b1, 10'd3, 24'hFFFFFF);
    set_b(1'b0, 1'b0, 10'd0, 24'h0);
    tick;
    check("gate_hold_a", douta, 24'h111111);
    check("gate_hold_b", doutb, 24'h222222);
    set_a(1'b1, 1'b0, 10'd3, 24'h0);
    tick;
    check("gate_rd3_a", douta, 24'h0);

    // 6. reset mid-operation: outputs clear, write still lands
    reset = 1'b1;
    set_a(1'b1, 1'b1, 10'd100, 24'h5A5A5A);
    set_b(1'b1, 1'b0, 10'd5, 24'h0);
    tick;
    check("rst_mid_a", douta, 24'h0);
    check("rst_mid_b", doutb, 24'h0);
    reset = 1'b0;
    set_a(1'b1, 1'b0, 10'd100, 24'h0);
    set_b(1'b1, 1'b0, 10'd100, 24'h0);
    tick;
    check("rd100_a", douta, 24'h5A5A5A);
    check("rd100_b", doutb, 24'h5A5A5A);
    set_a(1'b0, 1'b0, 10'd5, 24'h0);
    set_b(1'b0, 1'b0, 10'd5, 24'h0);
    tick; tick;
    check("hold100_a", douta, 24'h5A5A5A);
    check("hold100_b", doutb, 24'h5A5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ise_dpram_1kx24.md
Name: ise_dpram_1kx24

Overview:
- 1024-word x 24-bit true dual-port synchronous static RAM, used as the 1kx24 memory primitive (e.g. VMEM1 map storage).
- Two independent read/write ports, A and B, share one clock.
- Each port has a registered output with one cycle of read latency and a synchronous output reset.

Parameters:
- ADDR_WIDTH, 10, address bits per port.
- DATA_WIDTH, 24, word width in bits.
- DEPTH, 1024, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock for both ports; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the output registers only.
- ena  in  1  port A enable; gates both read and write on port A.
- wea  in  1  port A write enable; effective only when ena=1.
- addra  in  10  port A word address.
- dina  in  24  port A write data.
- douta  out  24  port A registered read data.
- enb  in  1  port B enable.
- web  in  1  port B write enable; effective only when enb=1.
- addrb  in  10  port B word address.
- dinb  in  24  port B write data.
- doutb  out  24  port B registered read data.

Behaviour:
- Storage: 1024 x 24 array, initialised to all zeros at time zero. Reset does not alter memory contents.
- Write, per port:
  - mem[addr] <= din at a rising edge when en=1 and we=1.
  - we is ignored when en=0.
- Read, per port:
  - At a rising edge with en=1, dout <= mem[addr].
  - Latency is exactly 1 cycle; data is valid after the edge that sampled the address.
- Output hold: when en=0, dout keeps its previous value indefinitely.
- Reset:
  - At a rising edge with reset=1, douta <= 0 and doutb <= 0. Reset has priority over reads.
  - Writes issued in a reset cycle still update memory.
  - Out of reset, douta = doutb = 0 until the first enabled read.
- Same-port read-during-write: read-first. dout receives the old contents of addr and the new data is stored; the new value is visible on the next enabled read.
- Mixed-port read-during-write, different ports on the same address in the same cycle: the reading port returns the old data.
- Simultaneous writes:
  - Different addresses: both writes take effect.
  - Same address: port A's data wins; port B's write is dropped.
  - Both ports' dout still return the old data (read-first).
- Addresses are the full 10 bits; there is no out-of-range case and no wrap logic.
- There are no handshakes, busy signals or error outputs.
- Port widths are derived from the parameters; every path is purely combinational into the registered outputs.

Test Plan:
1. Reset/hold: reset=1 for 2 cycles with ena=enb=1 -> douta=doutb=0. Then ena=enb=0 for 5 cycles -> outputs stay 0.
2. Basic write/read: A writes 24'o12345670 to addr 10'o17. Next cycle B reads 10'o17 (enb=1, web=0) -> doutb=24'o12345670 one cycle later. A read of 10'o17 -> douta=24'o12345670.
3. Read-first / mixed port, on addr 5 holding 24'h000001:
   - A writes 24'hABCDEF to addr 5 while B reads addr 5 -> douta=24'h000001 and doutb=24'h000001.
   - Next cycle both read addr 5 -> both 24'hABCDEF.
4. Write collision:
   - A writes 24'h111111 and B writes 24'h222222 to addr 1023 in the same cycle -> a subsequent read gives 24'h111111.
   - Same cycle, A to addr 0 and B to addr 1 -> mem[0]=24'h111111, mem[1]=24'h222222.
5. Enable gating:
   - ena=0, wea=1, dina=24'hFFFFFF at addr 3 -> a later read of addr 3 returns its prior value (0).
   - douta unchanged while ena=0.
6. Reset mid-operation:
   - reset=1 in the same cycle as an A write of 24'h5A5A5A to addr 100 and a B read -> douta=doutb=0.
   - After reset deasserts, reading addr 100 -> 24'h5A5A5A.
